// File: rtl/result_serial.sv
// result_serial: takes wide result vectors through a one-deep pending buffer and
// streams them out as STR_WIDTH beats, flagging the last beat of each frame.
module result_serial #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CFG_ADDR   = 6,
  parameter int DEPTH_NB   = 16,
  parameter int IMG_WIDTH  = 16,
  parameter int STR_WIDTH  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [IMG_WIDTH*DEPTH_NB-1:0] up_data,
  input  logic                          up_val,
  output logic                          up_rdy,
  output logic [STR_WIDTH-1:0]          dn_data,
  output logic                          dn_last,
  output logic                          dn_val,
  input  logic                          dn_rdy,
  output logic                          busy
);

  localparam int VEC_W = IMG_WIDTH * DEPTH_NB;
  localparam int BEATS = VEC_W / STR_WIDTH;
  localparam int BC_W  = $clog2(BEATS);
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'b01;
  localparam logic [1:0] ST_SEND = 2'b10;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [VEC_W-1:0] pend_r;
  logic             pend_val_r;
  logic [VEC_W-1:0] sr_r;
  logic [VEC_W-1:0] sr_nxt_s;
  logic [BC_W-1:0]  beat_cnt_r;
  logic [BC_W-1:0]  beat_cnt_nxt_s;
  logic [15:0]      vec_cnt_r;
  logic [15:0]      vec_cnt_nxt_s;
  logic [15:0]      frame_nb_r;
  logic             send_s;
  logic             beat_acc_s;
  logic             last_s;
  logic             unload_s;
  logic             up_acc_s;
  logic             cfg_hit_s;
  logic             cfg_unused_s;

  assign send_s       = (state_r == ST_SEND);
  assign last_s       = send_s & (beat_cnt_r == LAST_BEAT) & (vec_cnt_r >= frame_nb_r);
  assign beat_acc_s   = send_s & dn_rdy;
  assign up_rdy       = ~pend_val_r & ~rst;
  assign up_acc_s     = up_val & up_rdy;
  assign cfg_hit_s    = cfg_valid & (cfg_addr == CFG_AWIDTH'(CFG_ADDR));
  assign cfg_unused_s = ^cfg_data[CFG_DWIDTH-1:16];

  // Outputs come straight from state: the low slice of the shift register is the current beat.
  assign dn_data = sr_r[STR_WIDTH-1:0];
  assign dn_val  = send_s;
  assign dn_last = last_s;
  assign busy    = pend_val_r | send_s;

  // Serialiser next-state: load from pend, shift per accepted beat, reload without a bubble.
  always_comb begin
    state_nxt_s    = state_r;
    sr_nxt_s       = sr_r;
    beat_cnt_nxt_s = beat_cnt_r;
    vec_cnt_nxt_s  = vec_cnt_r;
    unload_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pend_val_r) begin
          sr_nxt_s       = pend_r;
          beat_cnt_nxt_s = {BC_W{1'b0}};
          unload_s       = 1'b1;
          state_nxt_s    = ST_SEND;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (beat_acc_s) begin
          if (beat_cnt_r == LAST_BEAT) begin
            beat_cnt_nxt_s = {BC_W{1'b0}};
            if (last_s) begin
              vec_cnt_nxt_s = 16'd0;
            end else begin
              vec_cnt_nxt_s = vec_cnt_r + 16'd1;
            end
            if (pend_val_r) begin
              sr_nxt_s    = pend_r;
              unload_s    = 1'b1;
              state_nxt_s = ST_SEND;
            end else begin
              sr_nxt_s    = sr_r >> STR_WIDTH;
              state_nxt_s = ST_IDLE;
            end
          end else begin
            beat_cnt_nxt_s = beat_cnt_r + BC_W'(1);
            sr_nxt_s       = sr_r >> STR_WIDTH;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        beat_cnt_nxt_s = {BC_W{1'b0}};
      end
    endcase
  end

  // Serialiser state, shift register and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sr_r       <= {VEC_W{1'b0}};
      beat_cnt_r <= {BC_W{1'b0}};
      vec_cnt_r  <= 16'd0;
    end else begin
      state_r    <= state_nxt_s;
      sr_r       <= sr_nxt_s;
      beat_cnt_r <= beat_cnt_nxt_s;
      vec_cnt_r  <= vec_cnt_nxt_s;
    end
  end

  // Pending buffer: filled by the upstream handshake, emptied when the serialiser loads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r     <= {VEC_W{1'b0}};
      pend_val_r <= 1'b0;
    end else if (up_acc_s) begin
      pend_r     <= up_data;
      pend_val_r <= 1'b1;
    end else if (unload_s) begin
      pend_val_r <= 1'b0;
    end else begin
      pend_val_r <= pend_val_r;
    end
  end

  // Frame length register; a write lands immediately, the current comparison sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_nb_r <= 16'd0;
    end else if (cfg_hit_s) begin
      frame_nb_r <= cfg_data[15:0];
    end else begin
      frame_nb_r <= frame_nb_r;
    end
  end

endmodule
